pwm_deadtime_gen: RTL

//  Downstream of the carrier comparator: converts the single-ended PWM decision into a complementary half-bridge gate pair.

---
 rtl/pwm_deadtime_if.sv | 21 ++
 rtl/pwm_deadtime_gen.sv | 62 ++++++
 2 files changed

// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if: control inputs and gate-drive outputs of the dead-time generator
interface pwm_deadtime_if #(parameter int DEAD_W = 8, parameter int CNT_W = 16);
  logic              en;
  logic              pwm_in;
  logic [DEAD_W-1:0] dead_cycles;
  logic              fault;
  logic              fault_clr;
  logic              gate_hi;
  logic              gate_lo;
  logic              dead_active;
  logic              fault_latched;
  logic [CNT_W-1:0]  sw_count;
  modport master (
    output en, pwm_in, dead_cycles, fault, fault_clr,
    input  gate_hi, gate_lo, dead_active, fault_latched, sw_count
  );
  modport slave (
    input  en, pwm_in, dead_cycles, fault, fault_clr,
    output gate_hi, gate_lo, dead_active, fault_latched, sw_count
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary half-bridge gate pair with dead time, fault latch and enable
module pwm_deadtime_gen #(
  parameter int DEAD_W = 8,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  pwm_deadtime_if.slave  bus
);
  typedef enum logic [2:0] {S_OFF, S_DEAD, S_HI, S_LO, S_FAULT} state_t;
  state_t            r_state, w_state;
  logic              r_pwm_q;
  logic              r_target, w_target;
  logic [DEAD_W-1:0] r_cnt, w_cnt;
  logic [CNT_W-1:0]  r_sw_count, w_sw_count;
  logic              w_enter;
  // registered PWM input, FSM state and dead-time datapath; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_pwm_q    <= 1'b0;
      r_target   <= 1'b0;
      r_cnt      <= '0;
      r_sw_count <= '0;
    end else begin
      r_state    <= w_state;
      r_pwm_q    <= bus.pwm_in;
      r_target   <= w_target;
      r_cnt      <= w_cnt;
      r_sw_count <= w_sw_count;
    end
  end
  // next state: fault first, then fault hold/clear, enable, dead-time entry and countdown
  always_comb begin
    w_state    = r_state;
    w_target   = r_target;
    w_cnt      = r_cnt;
    w_sw_count = r_sw_count;
    w_enter    = (r_state == S_OFF) || (r_state == S_HI && !r_pwm_q) || (r_state == S_LO && r_pwm_q);
    if (bus.fault) w_state = S_FAULT;
    else if (r_state == S_FAULT) w_state = bus.fault_clr ? S_OFF : S_FAULT;
    else if (!bus.en) w_state = S_OFF;
    else if (w_enter) begin
      w_state  = S_DEAD;
      w_target = r_pwm_q;
      w_cnt    = bus.dead_cycles;
    end else if (r_state == S_DEAD) begin
      if (r_cnt == '0) begin
        w_state    = r_target ? S_HI : S_LO;
        w_sw_count = r_sw_count + 1'b1;
      end else begin
        w_cnt    = r_cnt - 1'b1;
        w_target = r_pwm_q;
      end
    end
  end
  assign bus.gate_hi       = (r_state == S_HI);
  assign bus.gate_lo       = (r_state == S_LO);
  assign bus.dead_active   = (r_state == S_DEAD);
  assign bus.fault_latched = (r_state == S_FAULT);
  assign bus.sw_count      = r_sw_count;
endmodule
